// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pulls words out of a synchronous FIFO and presents them
// on a valid/ready stream, grouped into fixed-length packets. A 3-entry
// circular skid buffer absorbs the FIFO's one-cycle read latency, so read
// issue depends only on registered occupancy and never on m_ready.
module fifo_stream_drain #(
   parameter int width   = 16,
   parameter int pkt_len = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fifo_empty,
   input  logic [width-1:0] fifo_data_out,
   output logic             fifo_read,
   output logic [width-1:0] m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic [15:0]      pkt_cnt
);

   localparam int idx_w = (pkt_len > 1) ? $clog2(pkt_len) : 1;
   localparam logic [idx_w-1:0] last_idx = idx_w'(pkt_len - 1);

   // Circular pointer advance over the three buffer slots (2 wraps to 0).
   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      logic [1:0] nxt;
      if (ptr == 2'd2) begin
         nxt = 2'd0;
      end else begin
         nxt = ptr + 2'd1;
      end
      return nxt;
   endfunction

   logic [width-1:0] buf_q [3];
   logic [width-1:0] buf_d [3];
   logic [1:0]       head_q, head_d;
   logic [1:0]       tail_q, tail_d;
   logic [1:0]       occ_q, occ_d;
   logic             inflight_q, inflight_d;
   logic [idx_w-1:0] idx_q, idx_d;
   logic [15:0]      pkt_cnt_q, pkt_cnt_d;
   logic [2:0]       pending_s;
   logic             xfer_s;
   logic             cap_s;

   // Stream outputs come straight from registered state and buffer storage.
   assign m_valid = (occ_q != 2'd0);
   assign m_data  = buf_q[head_q];
   assign m_last  = (idx_q == last_idx);
   assign pkt_cnt = pkt_cnt_q;

   // Issue a FIFO read only when the word is guaranteed a free buffer slot.
   always_comb begin
      pending_s = {1'b0, occ_q} + {2'b00, inflight_q};
      fifo_read = en && !fifo_empty && (pending_s < 3'd3) && !rst;
   end

   // Next-state for buffer, pointers, occupancy and packet bookkeeping.
   always_comb begin
      xfer_s     = m_valid && m_ready;
      cap_s      = inflight_q;
      inflight_d = fifo_read;
      buf_d      = buf_q;
      tail_d     = tail_q;
      head_d     = head_q;
      occ_d      = occ_q;
      idx_d      = idx_q;
      pkt_cnt_d  = pkt_cnt_q;

      if (cap_s) begin
         buf_d[tail_q] = fifo_data_out;
         tail_d        = ptr_inc(tail_q);
      end else begin
         tail_d = tail_q;
      end

      if (xfer_s) begin
         head_d = ptr_inc(head_q);
         if (idx_q == last_idx) begin
            idx_d     = {idx_w{1'b0}};
            pkt_cnt_d = pkt_cnt_q + 16'd1;
         end else begin
            idx_d     = idx_q + {{(idx_w-1){1'b0}}, 1'b1};
            pkt_cnt_d = pkt_cnt_q;
         end
      end else begin
         head_d = head_q;
      end

      case ({cap_s, xfer_s})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // State registers; reset drops buffered and in-flight words.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            buf_q[i] <= {width{1'b0}};
         end
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         idx_q      <= {idx_w{1'b0}};
         pkt_cnt_q  <= 16'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            buf_q[i] <= buf_d[i];
         end
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         idx_q      <= idx_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain: a behavioural FIFO feeds the DUT
// (pkt_len=8) and a second instance (pkt_len=1). Inputs change on the falling
// edge, outputs are sampled shortly after it.
module tb_fifo_stream_drain;

   logic        clk;
   logic        rst;
   logic        en;
   logic        fifo_empty;
   logic [15:0] fifo_data_out = 16'h0000;
   logic        fifo_read;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic [15:0] pkt_cnt;

   logic        en1;
   logic        fe1;
   logic [15:0] fdo1 = 16'h0000;
   logic        frd1;
   logic [15:0] md1;
   logic        mv1;
   logic        ml1;
   logic        mr1;
   logic [15:0] pc1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] fmem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic [15:0] f1mem [0:7];
   int          w1 = 0;
   int          r1 = 0;

   logic [15:0] got_data [$];
   logic        got_last [$];
   int rd_cnt, first_rd, first_vld, first_x, last_x;
   int stab_viol = 0;
   int occ_viol  = 0;
   int issued    = 0;
   int xferd     = 0;

   fifo_stream_drain #(.width(16), .pkt_len(8)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_read(fifo_read),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
      .m_ready(m_ready), .pkt_cnt(pkt_cnt)
   );

   fifo_stream_drain #(.width(16), .pkt_len(1)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .fifo_empty(fe1),
      .fifo_data_out(fdo1), .fifo_read(frd1),
      .m_data(md1), .m_valid(mv1), .m_last(ml1),
      .m_ready(mr1), .pkt_cnt(pc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FIFOs: one-cycle registered read data, empty flag is live.
   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fe1        = (r1 == w1);
   always @(posedge clk) begin
      if (fifo_read) begin
         fifo_data_out <= fmem[rd_ptr[7:0]];
         rd_ptr        <= rd_ptr + 1;
      end
      if (frd1) begin
         fdo1 <= f1mem[r1[2:0]];
         r1   <= r1 + 1;
      end
   end

   task automatic push(input logic [15:0] v);
      fmem[wr_ptr[7:0]] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   // Runs up to max_cyc cycles collecting transfers; stops once target words seen.
   task automatic run(input int max_cyc, input int target, input bit rnd);
      logic        prev_stall;
      logic [15:0] prev_d;
      logic        prev_l;
      prev_stall = 1'b0;
      prev_d     = 16'h0000;
      prev_l     = 1'b0;
      rd_cnt = 0; first_rd = -1; first_vld = -1; first_x = -1; last_x = -1;
      for (int c = 0; c < max_cyc; c++) begin
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         #1;
         if ((issued - xferd) > 3) occ_viol++;
         if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stab_viol++;
         if (fifo_read) begin
            rd_cnt++;
            issued++;
            if (first_rd < 0) first_rd = c;
         end
         if (m_valid && first_vld < 0) first_vld = c;
         if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            xferd++;
            if (first_x < 0) first_x = c;
            last_x = c;
         end
         prev_stall = m_valid && !m_ready;
         prev_d     = m_data;
         prev_l     = m_last;
         @(negedge clk);
         if (got_data.size() >= target) break;
      end
   endtask

   task automatic test_reset();
      for (int i = 1; i <= 16; i++) push(16'(i));
      rst = 1'b1; en = 1'b1; m_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
      n_checks++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
      n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
      n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
      n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_read: got %b expected 0", fifo_read); end
      n_checks++; if (mv1 !== 1'b0 || pc1 !== 16'd0) begin n_fail++; $display("FAIL reset_dut1: got valid %b cnt %0d expected 0 0", mv1, pc1); end
      @(negedge clk);
   endtask

   task automatic test_stream();
      got_data.delete(); got_last.delete();
      rst = 1'b0;
      run(40, 16, 1'b0);
      n_checks++; if (first_rd !== 0) begin n_fail++; $display("FAIL stream_first_read: got cycle %0d expected 0", first_rd); end
      n_checks++; if (first_vld !== 2) begin n_fail++; $display("FAIL stream_latency: got cycle %0d expected 2", first_vld); end
      n_checks++; if (got_data.size() !== 16) begin n_fail++; $display("FAIL stream_count: got %0d expected 16", got_data.size()); end
      n_checks++; if (last_x - first_x !== 15) begin n_fail++; $display("FAIL stream_rate: got span %0d expected 15", last_x - first_x); end
      for (int i = 0; i < got_data.size(); i++) begin
         n_checks++; if (got_data[i] !== 16'(i + 1) || got_last[i] !== ((i % 8) == 7)) begin
            n_fail++; $display("FAIL stream_word%0d: got %h last %b expected %h last %b", i, got_data[i], got_last[i], 16'(i + 1), ((i % 8) == 7));
         end
      end
      #1;
      n_checks++; if (pkt_cnt !== 16'd2) begin n_fail++; $display("FAIL stream_pkt_cnt: got %0d expected 2", pkt_cnt); end
      @(negedge clk);
   endtask

   task automatic test_stall();
      got_data.delete(); got_last.delete();
      m_ready = 1'b0;
      for (int i = 1; i <= 16; i++) push(16'(i));
      run(10, 999, 1'b0);
      n_checks++; if (rd_cnt !== 3) begin n_fail++; $display("FAIL stall_reads: got %0d expected 3", rd_cnt); end
      n_checks++; if (first_vld !== 2) begin n_fail++; $display("FAIL stall_latency: got cycle %0d expected 2", first_vld); end
      n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", stab_viol); end
      #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin n_fail++; $display("FAIL stall_head: got valid %b data %h expected 1 0001", m_valid, m_data); end
      m_ready = 1'b1;
      run(40, 16, 1'b0);
      n_checks++; if (got_data.size() !== 16) begin n_fail++; $display("FAIL stall_count: got %0d expected 16", got_data.size()); end
      for (int i = 0; i < got_data.size(); i++) begin
         n_checks++; if (got_data[i] !== 16'(i + 1) || got_last[i] !== ((i % 8) == 7)) begin
            n_fail++; $display("FAIL stall_word%0d: got %h last %b expected %h", i, got_data[i], got_last[i], 16'(i + 1));
         end
      end
      #1;
      n_checks++; if (pkt_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_pkt_cnt: got %0d expected 4", pkt_cnt); end
      @(negedge clk);
   endtask

   task automatic test_random_ready();
      got_data.delete(); got_last.delete();
      for (int i = 0; i < 64; i++) push(16'h0100 + 16'(i));
      run(2000, 64, 1'b1);
      m_ready = 1'b1;
      n_checks++; if (got_data.size() !== 64) begin n_fail++; $display("FAIL rand_count: got %0d expected 64", got_data.size()); end
      for (int i = 0; i < got_data.size(); i++) begin
         n_checks++; if (got_data[i] !== (16'h0100 + 16'(i)) || got_last[i] !== ((i % 8) == 7)) begin
            n_fail++; $display("FAIL rand_word%0d: got %h last %b expected %h", i, got_data[i], got_last[i], 16'h0100 + 16'(i));
         end
      end
      n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rand_hold: got %0d changes expected 0", stab_viol); end
      n_checks++; if (occ_viol !== 0) begin n_fail++; $display("FAIL rand_occupancy: got %0d overflows expected 0", occ_viol); end
      #1;
      n_checks++; if (pkt_cnt !== 16'd12) begin n_fail++; $display("FAIL rand_pkt_cnt: got %0d expected 12", pkt_cnt); end
      @(negedge clk);
   endtask

   task automatic test_enable();
      got_data.delete(); got_last.delete();
      m_ready = 1'b1; en = 1'b1;
      for (int i = 1; i <= 16; i++) push(16'(i));
      run(3, 999, 1'b0);
      en = 1'b0;
      run(5, 999, 1'b0);
      n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL en_reads: got %0d expected 0", rd_cnt); end
      n_checks++; if (got_data.size() !== 3) begin n_fail++; $display("FAIL en_drain: got %0d words expected 3", got_data.size()); end
      en = 1'b1;
      run(40, 16, 1'b0);
      n_checks++; if (got_data.size() !== 16) begin n_fail++; $display("FAIL en_count: got %0d expected 16", got_data.size()); end
      for (int i = 0; i < got_data.size(); i++) begin
         n_checks++; if (got_data[i] !== 16'(i + 1) || got_last[i] !== ((i % 8) == 7)) begin
            n_fail++; $display("FAIL en_word%0d: got %h last %b expected %h", i, got_data[i], got_last[i], 16'(i + 1));
         end
      end
      #1;
      n_checks++; if (pkt_cnt !== 16'd14) begin n_fail++; $display("FAIL en_pkt_cnt: got %0d expected 14", pkt_cnt); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_packet();
      got_data.delete(); got_last.delete();
      m_ready = 1'b1; en = 1'b1;
      for (int i = 1; i <= 16; i++) push(16'(i));
      run(40, 5, 1'b0);
      m_ready = 1'b0;
      run(1, 999, 1'b0);
      #1;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 16'h0006) begin n_fail++; $display("FAIL rstmid_pre: got valid %b data %h expected 1 0006", m_valid, m_data); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", m_valid); end
      n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_pkt_cnt: got %0d expected 0", pkt_cnt); end
      n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_read: got %b expected 0", fifo_read); end
      rst = 1'b0; m_ready = 1'b1;
      issued = 0; xferd = 0;
      got_data.delete(); got_last.delete();
      run(40, 8, 1'b0);
      n_checks++; if (got_data.size() !== 8) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 8", got_data.size()); end
      for (int i = 0; i < got_data.size(); i++) begin
         n_checks++; if (got_data[i] !== 16'(i + 9) || got_last[i] !== (i == 7)) begin
            n_fail++; $display("FAIL rstmid_word%0d: got %h last %b expected %h last %b", i, got_data[i], got_last[i], 16'(i + 9), (i == 7));
         end
      end
      #1;
      n_checks++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL rstmid_pkt_cnt_after: got %0d expected 1", pkt_cnt); end
      @(negedge clk);
   endtask

   task automatic test_pkt_len_one();
      int n1;
      n1 = 0;
      for (int i = 0; i < 3; i++) begin
         f1mem[w1[2:0]] = 16'h00A1 + 16'(i);
         w1 = w1 + 1;
      end
      en1 = 1'b1; mr1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         n_checks++; if (pc1 !== 16'(n1)) begin n_fail++; $display("FAIL len1_cnt_c%0d: got %0d expected %0d", c, pc1, n1); end
         if (mv1 && mr1) begin
            n_checks++; if (ml1 !== 1'b1 || md1 !== (16'h00A1 + 16'(n1))) begin
               n_fail++; $display("FAIL len1_word%0d: got %h last %b expected %h last 1", n1, md1, ml1, 16'h00A1 + 16'(n1));
            end
            n1++;
         end
         @(negedge clk);
      end
      #1;
      n_checks++; if (n1 !== 3 || pc1 !== 16'd3) begin n_fail++; $display("FAIL len1_total: got %0d words cnt %0d expected 3 3", n1, pc1); end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; m_ready = 1'b1; en1 = 1'b0; mr1 = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_random_ready();
      test_enable();
      test_reset_mid_packet();
      test_pkt_len_one();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
